// File: rtl/kpn_pkg.sv
// Shared KPN definitions: process FSM states and the default channel token width.
package kpn_pkg;

  localparam int KPN_BITS_NUMBER = 16;

  typedef enum logic [2:0] {
    READ_1,
    LATCH_1,
    READ_2,
    LATCH_2,
    WRITE
  } kpn_proc_state_t;

endpackage

// File: rtl/kpn_blocking_reader.sv
// Kahn blocking read for one input channel: pops when asked and the channel is
// non-empty, then captures the token the channel presents on the following cycle.
module kpn_blocking_reader
  import kpn_pkg::*;
#(
  parameter int BITS_NUMBER = KPN_BITS_NUMBER
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   request,
  input  logic                   capture,
  input  logic                   empty,
  input  logic [BITS_NUMBER-1:0] entry,
  output logic                   rd,
  output logic [BITS_NUMBER-1:0] token
);

  logic [BITS_NUMBER-1:0] held;

  always_ff @(posedge clk) begin
    if (reset) begin
      held <= '0;
    end else if (capture) begin
      held <= entry;
    end
  end

  assign rd = request & ~empty;

  // While capturing, expose the arriving token so the consumer can use it in the same cycle.
  assign token = capture ? entry : held;

endmodule

// File: rtl/kpn_adder_process.sv
// KPN adder node: reads one token from channel 1, then one from channel 2, and writes
// their sum to the output channel. Define KPN_ADDER_SATURATE_EN for a saturating add.
module kpn_adder_process
  import kpn_pkg::*;
#(
  parameter int BITS_NUMBER = KPN_BITS_NUMBER,
  parameter int COUNT_BITS  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   empty_1,
  input  logic [BITS_NUMBER-1:0] entry_1,
  output logic                   rd_1,
  input  logic                   empty_2,
  input  logic [BITS_NUMBER-1:0] entry_2,
  output logic                   rd_2,
  input  logic                   full_out,
  output logic                   wr_out,
  output logic [BITS_NUMBER-1:0] output_1,
  output logic [COUNT_BITS-1:0]  tokens_done
);

  kpn_proc_state_t        state, next_state;
  logic [BITS_NUMBER-1:0] op_a, op_b, sum;

  kpn_blocking_reader #(.BITS_NUMBER(BITS_NUMBER)) reader_1 (
    .clk     (clk),
    .reset   (reset),
    .request (state == READ_1),
    .capture (state == LATCH_1),
    .empty   (empty_1),
    .entry   (entry_1),
    .rd      (rd_1),
    .token   (op_a)
  );

  kpn_blocking_reader #(.BITS_NUMBER(BITS_NUMBER)) reader_2 (
    .clk     (clk),
    .reset   (reset),
    .request (state == READ_2),
    .capture (state == LATCH_2),
    .empty   (empty_2),
    .entry   (entry_2),
    .rd      (rd_2),
    .token   (op_b)
  );

`ifdef KPN_ADDER_SATURATE_EN
  logic [BITS_NUMBER:0] wide_sum;

  always_comb begin
    wide_sum = {1'b0, op_a} + {1'b0, op_b};
    sum      = wide_sum[BITS_NUMBER] ? '1 : wide_sum[BITS_NUMBER-1:0];
  end
`else
  assign sum = op_a + op_b;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= READ_1;
      output_1    <= '0;
      tokens_done <= '0;
    end else begin
      state <= next_state;
      if (state == LATCH_2) begin
        output_1 <= sum;
      end
      if (wr_out) begin
        tokens_done <= tokens_done + 1'b1;
      end
    end
  end

  always_comb begin
    next_state = state;
    wr_out     = 1'b0;
    case (state)
      READ_1:  if (rd_1) next_state = LATCH_1;
      LATCH_1: next_state = READ_2;
      READ_2:  if (rd_2) next_state = LATCH_2;
      LATCH_2: next_state = WRITE;
      WRITE: begin
        if (!full_out) begin
          wr_out     = 1'b1;
          next_state = READ_1;
        end
      end
      default: next_state = READ_1;
    endcase
  end

endmodule

// File: tb/tb_kpn_adder_process.sv
// Self-checking bench for kpn_adder_process: FIFO channel models, a Kahn-semantics
// result model checked every cycle, and directed scenarios with literal expectations.
module tb_kpn_adder_process;

  logic        clk = 1'b0;
  logic        reset;
  logic        empty_1, empty_2, full_out;
  logic [15:0] entry_1, entry_2;
  logic        rd_1, rd_2, wr_out;
  logic [15:0] output_1;
  logic [15:0] tokens_done;

  always #5 clk = ~clk;

  kpn_adder_process dut (
    .clk         (clk),
    .reset       (reset),
    .empty_1     (empty_1),
    .entry_1     (entry_1),
    .rd_1        (rd_1),
    .empty_2     (empty_2),
    .entry_2     (entry_2),
    .rd_2        (rd_2),
    .full_out    (full_out),
    .wr_out      (wr_out),
    .output_1    (output_1),
    .tokens_done (tokens_done)
  );

  int assertions = 0;
  int failures   = 0;

  logic [15:0] ch1Q[$];
  logic [15:0] ch2Q[$];
  logic [15:0] pendingA[$];
  logic [15:0] expQ[$];
  logic [15:0] wrLog[$];
  int          wrCycLog[$];
  logic [15:0] modelDone = '0;

  int   cyc = 0, rd1Count = 0, rd2Count = 0, wrCount = 0;
  int   lastRd1Cyc = 0, lastWrCyc = 0;
  logic prevRd1 = 1'b0, prevRd2 = 1'b0, prevWr = 1'b0;
  logic pop1 = 1'b0, pop2 = 1'b0;

  function automatic logic [15:0] modelAdd(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
`ifdef KPN_ADDER_SATURATE_EN
    return s[16] ? 16'hFFFF : s[15:0];
`else
    return s[15:0];
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int channel, input logic [15:0] value);
    if (channel == 1) begin
      ch1Q.push_back(value);
      empty_1 = 1'b0;
    end else begin
      ch2Q.push_back(value);
      empty_2 = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic waitWrites(input int target, input int budget);
    int n = 0;
    while (wrCount < target && n < budget) begin
      step();
      n++;
    end
    checkOutput("write_timeout", 32'(wrCount >= target), 32'd1);
  endtask

  function automatic logic [15:0] lastWritten();
    return (wrLog.size() > 0) ? wrLog[wrLog.size()-1] : 16'hDEAD;
  endfunction

  // Channel FIFOs: a pop seen during a cycle takes effect just after the next edge.
  always @(posedge clk) begin
    #1;
    if (pop1 && ch1Q.size() > 0) entry_1 = ch1Q.pop_front();
    if (pop2 && ch2Q.size() > 0) entry_2 = ch2Q.pop_front();
    pop1    = 1'b0;
    pop2    = 1'b0;
    empty_1 = (ch1Q.size() == 0);
    empty_2 = (ch2Q.size() == 0);
  end

  // Per-cycle protocol and result checks against the Kahn model.
  always @(negedge clk) begin
    cyc++;
    pop1 = rd_1;
    pop2 = rd_2;
    if (reset) begin
      pendingA.delete();
      expQ.delete();
      modelDone = '0;
      prevRd1   = 1'b0;
      prevRd2   = 1'b0;
      prevWr    = 1'b0;
    end else begin
      checkOutput("tokens_done_model", 32'(tokens_done), 32'(modelDone));
      if (rd_1) begin
        checkOutput("rd_1_while_empty", 32'(empty_1), 32'd0);
        checkOutput("rd_1_with_wr_out", 32'(wr_out), 32'd0);
        checkOutput("rd_1_back_to_back", 32'(prevRd1), 32'd0);
        if (ch1Q.size() > 0) pendingA.push_back(ch1Q[0]);
        rd1Count++;
        lastRd1Cyc = cyc;
      end
      if (rd_2) begin
        checkOutput("rd_2_while_empty", 32'(empty_2), 32'd0);
        checkOutput("rd_2_back_to_back", 32'(prevRd2), 32'd0);
        checkOutput("rd_2_before_rd_1", 32'(pendingA.size() > 0), 32'd1);
        if (pendingA.size() > 0 && ch2Q.size() > 0)
          expQ.push_back(modelAdd(pendingA.pop_front(), ch2Q[0]));
        rd2Count++;
      end
      if (wr_out) begin
        checkOutput("wr_out_while_full", 32'(full_out), 32'd0);
        checkOutput("wr_out_back_to_back", 32'(prevWr), 32'd0);
        checkOutput("result_expected", 32'(expQ.size() > 0), 32'd1);
        if (expQ.size() > 0) checkOutput("output_1_model", 32'(output_1), 32'(expQ.pop_front()));
        modelDone++;
        wrCount++;
        lastWrCyc = cyc;
        wrLog.push_back(output_1);
        wrCycLog.push_back(cyc);
      end
      prevRd1 = rd_1;
      prevRd2 = rd_2;
      prevWr  = wr_out;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation watchdog expired");
  end

  initial begin
    int b1, b2, bw, base;
    reset    = 1'b1;
    empty_1  = 1'b1;
    empty_2  = 1'b1;
    full_out = 1'b0;
    entry_1  = '0;
    entry_2  = '0;
    repeat (3) step();
    reset = 1'b0;

    checkOutput("reset_rd_1", 32'(rd_1), 32'd0);
    checkOutput("reset_rd_2", 32'(rd_2), 32'd0);
    checkOutput("reset_wr_out", 32'(wr_out), 32'd0);
    checkOutput("reset_output_1", 32'(output_1), 32'd0);
    checkOutput("reset_tokens_done", 32'(tokens_done), 32'd0);

    // Single pair, no stalls.
    bw = wrCount;
    applyStimulus(1, 16'd10);
    applyStimulus(2, 16'd20);
    waitWrites(bw + 1, 40);
    checkOutput("t1_sum", 32'(lastWritten()), 32'd30);
    checkOutput("t1_latency", 32'(lastWrCyc - lastRd1Cyc), 32'd4);
    checkOutput("t1_tokens_done", 32'(tokens_done), 32'd1);

    // Channel 2 starves for 20 cycles.
    b1 = rd1Count;
    b2 = rd2Count;
    bw = wrCount;
    applyStimulus(1, 16'd5);
    repeat (20) step();
    checkOutput("t2_no_rd_2", 32'(rd2Count - b2), 32'd0);
    checkOutput("t2_no_write", 32'(wrCount - bw), 32'd0);
    checkOutput("t2_rd_1_once", 32'(rd1Count - b1), 32'd1);
    applyStimulus(2, 16'd7);
    waitWrites(bw + 1, 40);
    checkOutput("t2_sum", 32'(lastWritten()), 32'd12);
    checkOutput("t2_rd_1_still_once", 32'(rd1Count - b1), 32'd1);

    // Output channel full for 10 cycles.
    full_out = 1'b1;
    bw = wrCount;
    applyStimulus(1, 16'd3);
    applyStimulus(2, 16'd4);
    for (int i = 0; i < 10; i++) begin
      step();
      if (i >= 5) begin
        checkOutput("t3_output_held", 32'(output_1), 32'd7);
        checkOutput("t3_wr_out_low", 32'(wr_out), 32'd0);
      end
    end
    checkOutput("t3_no_write", 32'(wrCount - bw), 32'd0);
    full_out = 1'b0;
    step();
    checkOutput("t3_write_on_release", 32'(wrCount - bw), 32'd1);
    checkOutput("t3_sum", 32'(lastWritten()), 32'd7);
    repeat (3) step();
    checkOutput("t3_single_write", 32'(wrCount - bw), 32'd1);

    // Carry-out boundary.
    bw = wrCount;
    applyStimulus(1, 16'hFFF0);
    applyStimulus(2, 16'h0020);
    waitWrites(bw + 1, 40);
`ifdef KPN_ADDER_SATURATE_EN
    checkOutput("t4_overflow", 32'(lastWritten()), 32'h0000FFFF);
`else
    checkOutput("t4_overflow", 32'(lastWritten()), 32'h00000010);
`endif

    // Four-token stream.
    bw = wrCount;
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1, 16'(10 * i));
      applyStimulus(2, 16'(i));
    end
    waitWrites(bw + 4, 80);
    base = wrLog.size() - 4;
    if (base >= 0) begin
      checkOutput("t5_out_0", 32'(wrLog[base]), 32'd11);
      checkOutput("t5_out_1", 32'(wrLog[base+1]), 32'd22);
      checkOutput("t5_out_2", 32'(wrLog[base+2]), 32'd33);
      checkOutput("t5_out_3", 32'(wrLog[base+3]), 32'd44);
      for (int i = 1; i < 4; i++)
        checkOutput("t5_service_time", 32'(wrCycLog[base+i] - wrCycLog[base+i-1]), 32'd5);
    end
    checkOutput("t5_tokens_done", 32'(tokens_done), 32'd8);

    // Reset while in LATCH_2.
    b2 = rd2Count;
    applyStimulus(1, 16'd9);
    applyStimulus(2, 16'd6);
    for (int n = 0; n < 20 && rd2Count == b2; n++) step();
    checkOutput("t6_rd_2_seen", 32'(rd2Count - b2), 32'd1);
    reset = 1'b1;
    step();
    checkOutput("t6_rd_1", 32'(rd_1), 32'd0);
    checkOutput("t6_rd_2", 32'(rd_2), 32'd0);
    checkOutput("t6_wr_out", 32'(wr_out), 32'd0);
    checkOutput("t6_output_1", 32'(output_1), 32'd0);
    checkOutput("t6_tokens_done", 32'(tokens_done), 32'd0);
    reset = 1'b0;
    bw = wrCount;
    applyStimulus(1, 16'd100);
    applyStimulus(2, 16'd23);
    waitWrites(bw + 1, 40);
    checkOutput("t6_sum", 32'(lastWritten()), 32'd123);
    checkOutput("t6_tokens_done_after", 32'(tokens_done), 32'd1);

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
